// File: rtl/adder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : adder_pkg                                                     |
// | Purpose  : Shared types and constants for the shared-adder controller.   |
// |            Holds the controller state encoding, the operand and result   |
// |            widths, and the default adder latency.                        |
// | Revision : 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
package adder_pkg;

  localparam int c_op_w          = 3;  // adder operand width
  localparam int c_res_w         = 4;  // adder result width (carry included)
  localparam int c_adder_lat_def = 1;  // default adder latency in cycles

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage : adder_pkg
`default_nettype wire

// File: rtl/adder_share_ctrl_rr_arb2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : rr_arb2                                                       |
// | Purpose  : Combinational two-way round-robin pick.                       |
// |            A lone request wins outright; when both request, the one not  |
// |            served last wins. The last-served pointer lives in the parent.|
// | Ports    : req  [1:0] in  - request vector                               |
// |            last       in  - index of the requester served last           |
// |            win  [1:0] out - one-hot winner (0 when nothing requests)     |
// |            any        out - at least one request present                 |
// | Revision : 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win,
  output logic       any
);

  always_comb begin
    win = 2'b00;
    unique case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      // Both asking: favour whichever was not served last.
      2'b11:   win = last ? 2'b01 : 2'b10;
      default: win = 2'b00;
    endcase
  end

  assign any = |req;

endmodule : rr_arb2
`default_nettype wire

// File: rtl/adder_share_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : adder_share_ctrl                                              |
// | Purpose  : Time-shares one clocked 3-bit adder/subtractor between two    |
// |            requesters. Arbitrates round-robin, registers the winner's    |
// |            operands onto the adder, waits out the adder latency, then    |
// |            captures the result/overflow and pulses done to the winner.   |
// | Ports    : clk, rst            - clock, synchronous active-high reset    |
// |            req[1:0]            - level requests, held until done         |
// |            a0,b0,cm1_0         - requester 0 operands and mode           |
// |            a1,b1,cm1_1         - requester 1 operands and mode           |
// |            add_a,add_b,add_cm1 - registered adder inputs                 |
// |            sum_in, ov_in       - adder result and overflow               |
// |            grant[1:0]          - one-hot owner of the adder              |
// |            done[1:0]           - one-cycle completion pulse              |
// |            res_data, res_ov    - last captured result, held              |
// |            busy                - controller not idle                     |
// | Revision : 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
module adder_share_ctrl
  import adder_pkg::*;
#(
  parameter int ADDER_LAT = c_adder_lat_def
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req,
  input  logic [c_op_w-1:0]   a0,
  input  logic [c_op_w-1:0]   b0,
  input  logic                cm1_0,
  input  logic [c_op_w-1:0]   a1,
  input  logic [c_op_w-1:0]   b1,
  input  logic                cm1_1,
  output logic [c_op_w-1:0]   add_a,
  output logic [c_op_w-1:0]   add_b,
  output logic                add_cm1,
  input  logic [c_res_w-1:0]  sum_in,
  input  logic                ov_in,
  output logic [1:0]          grant,
  output logic [1:0]          done,
  output logic [c_res_w-1:0]  res_data,
  output logic                res_ov,
  output logic                busy
);

  // Counter preload: WAIT runs for ADDER_LAT cycles, capturing on the last.
  localparam logic [2:0] c_lat_m1 = 3'(ADDER_LAT - 1);

  state_t              r_state;
  state_t              w_state_nx;
  logic [2:0]          r_cnt;
  logic [2:0]          w_cnt_nx;
  logic                r_last;       // index of the requester served last
  logic                w_last_nx;
  logic [c_op_w-1:0]   w_a_nx;
  logic [c_op_w-1:0]   w_b_nx;
  logic                w_cm1_nx;
  logic [1:0]          w_grant_nx;
  logic [1:0]          w_done_nx;
  logic [c_res_w-1:0]  w_res_nx;
  logic                w_ov_nx;
  logic                w_busy_nx;
  logic [1:0]          w_win;
  logic                w_any;

  rr_arb2 u_arb (
    .req  (req),
    .last (r_last),
    .win  (w_win),
    .any  (w_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 3'd0;
      r_last   <= 1'b1;   // requester 0 gets first priority
      add_a    <= '0;
      add_b    <= '0;
      add_cm1  <= 1'b0;
      grant    <= 2'b00;
      done     <= 2'b00;
      res_data <= '0;
      res_ov   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_last   <= w_last_nx;
      add_a    <= w_a_nx;
      add_b    <= w_b_nx;
      add_cm1  <= w_cm1_nx;
      grant    <= w_grant_nx;
      done     <= w_done_nx;
      res_data <= w_res_nx;
      res_ov   <= w_ov_nx;
      busy     <= w_busy_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_last_nx  = r_last;
    w_a_nx     = add_a;
    w_b_nx     = add_b;
    w_cm1_nx   = add_cm1;
    w_grant_nx = grant;
    w_done_nx  = 2'b00;
    w_res_nx   = res_data;
    w_ov_nx    = res_ov;

    unique case (r_state)
      ST_IDLE: begin
        w_grant_nx = 2'b00;
        if (w_any) begin
          // Operands are only ever sampled here, so the adder inputs and
          // cm1 stay frozen for the whole operation.
          if (w_win[1]) begin
            w_a_nx   = a1;
            w_b_nx   = b1;
            w_cm1_nx = cm1_1;
          end else begin
            w_a_nx   = a0;
            w_b_nx   = b0;
            w_cm1_nx = cm1_0;
          end
          w_grant_nx = w_win;
          w_cnt_nx   = c_lat_m1;
          w_state_nx = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (r_cnt == 3'd0) begin
          w_res_nx   = sum_in;
          w_ov_nx    = ov_in;
          w_done_nx  = grant;
          w_state_nx = ST_DONE;
        end else begin
          w_cnt_nx = r_cnt - 3'd1;
        end
      end
      ST_DONE: begin
        w_last_nx  = grant[1];
        w_grant_nx = 2'b00;
        w_state_nx = ST_IDLE;
      end
      default: begin
        w_grant_nx = 2'b00;
        w_state_nx = ST_IDLE;
      end
    endcase

    w_busy_nx = (w_state_nx != ST_IDLE);
  end

endmodule : adder_share_ctrl
`default_nettype wire
